// File: rtl/pipe_ctrl_tracker_pkg.sv
// Shared control-rod bit map and forwarding encodings for the EX/MEM/WB control tracker.
package pipe_ctrl_tracker_pkg;

    localparam int unsigned CR_ALU_LSB = 0;
    localparam int unsigned CR_BRANCH  = 3;
    localparam int unsigned CR_LOAD    = 4;
    localparam int unsigned CR_MEMWR   = 5;
    localparam int unsigned CR_REGWR   = 6;
    localparam int unsigned CR_JMP     = 7;
    localparam int unsigned CR_RD_RS2  = 8;
    localparam int unsigned CR_RD_RS1  = 9;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // The younger producer (MEM) wins over the older one (WB).
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_tracker_if.sv
// ID-stage inputs and pipeline control outputs of the tracker.
interface pipe_ctrl_tracker_if #(
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned RA_W   = 4,
    parameter int unsigned CNT_W  = 16
) ();
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [RA_W-1:0]   id_rs1;
    logic [RA_W-1:0]   id_rs2;
    logic [RA_W-1:0]   id_rd;
    logic              ex_branch_taken;
    logic              stall;
    logic              flush_ifid;
    logic              redirect;
    logic [2:0]        ex_alu_op;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_we;
    logic              mem_re;
    logic              wb_we;
    logic [RA_W-1:0]   wb_rd;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_branch_taken,
        input  stall, flush_ifid, redirect, ex_alu_op, fwd_a, fwd_b,
        input  mem_we, mem_re, wb_we, wb_rd, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_ctrl, id_rs1, id_rs2, id_rd, ex_branch_taken,
        output stall, flush_ifid, redirect, ex_alu_op, fwd_a, fwd_b,
        output mem_we, mem_re, wb_we, wb_rd, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register (valid, control rod, destination) with bubble insertion.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned RA_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bubble_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [RA_W-1:0]   rd_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [RA_W-1:0]   rd_o
);
    logic              valid_d, valid_q;
    logic [CTRL_W-1:0] ctrl_d, ctrl_q;
    logic [RA_W-1:0]   rd_d, rd_q;

    always_comb begin
        valid_d = valid_i & ~bubble_i;
        ctrl_d  = bubble_i ? '0 : ctrl_i;
        rd_d    = bubble_i ? '0 : rd_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign rd_o    = rd_q;
endmodule

// File: rtl/pipe_ctrl_tracker.sv
// Carries decoded control down EX/MEM/WB; resolves load-use stalls, redirects and forwarding.
module pipe_ctrl_tracker
    import pipe_ctrl_tracker_pkg::*;
#(
    parameter int unsigned CTRL_W = 10,
    parameter int unsigned RA_W   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic                clk,
    input logic                rst_n,
    pipe_ctrl_tracker_if.slave bus
);
    logic              ex_valid, mem_valid, wb_valid;
    logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [RA_W-1:0]   ex_rd, mem_rd, wb_rd;
    logic [RA_W-1:0]   ex_rs1_d, ex_rs1_q, ex_rs2_d, ex_rs2_q;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
    logic              redirect, hazard, stall, ex_bubble;
    logic              mem_fwd_ok, wb_fwd_ok;

    always_comb begin
        redirect  = ex_valid & (ex_ctrl[CR_JMP] | (ex_ctrl[CR_BRANCH] & bus.ex_branch_taken));
        hazard    = bus.id_valid & ex_valid & ex_ctrl[CR_LOAD] & ex_ctrl[CR_REGWR] &
                    ((bus.id_ctrl[CR_RD_RS1] & (bus.id_rs1 == ex_rd)) |
                     (bus.id_ctrl[CR_RD_RS2] & (bus.id_rs2 == ex_rd)));
        stall     = hazard & ~redirect;
        ex_bubble = redirect | stall | ~bus.id_valid;
        ex_rs1_d  = ex_bubble ? '0 : bus.id_rs1;
        ex_rs2_d  = ex_bubble ? '0 : bus.id_rs2;
    end

    pipe_stage_reg #(.CTRL_W(CTRL_W), .RA_W(RA_W)) u_ex (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble_i(ex_bubble),
        .valid_i (bus.id_valid),
        .ctrl_i  (bus.id_ctrl),
        .rd_i    (bus.id_rd),
        .valid_o (ex_valid),
        .ctrl_o  (ex_ctrl),
        .rd_o    (ex_rd)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .RA_W(RA_W)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble_i(1'b0),
        .valid_i (ex_valid),
        .ctrl_i  (ex_ctrl),
        .rd_i    (ex_rd),
        .valid_o (mem_valid),
        .ctrl_o  (mem_ctrl),
        .rd_o    (mem_rd)
    );

    pipe_stage_reg #(.CTRL_W(CTRL_W), .RA_W(RA_W)) u_wb (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble_i(1'b0),
        .valid_i (mem_valid),
        .ctrl_i  (mem_ctrl),
        .rd_i    (mem_rd),
        .valid_o (wb_valid),
        .ctrl_o  (wb_ctrl),
        .rd_o    (wb_rd)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // A load sitting in MEM has no data yet, so it is never a forwarding source.
    always_comb begin
        mem_fwd_ok = mem_valid & mem_ctrl[CR_REGWR] & ~mem_ctrl[CR_LOAD];
        wb_fwd_ok  = wb_valid & wb_ctrl[CR_REGWR];
    end

    assign bus.fwd_a      = fwd_sel(mem_fwd_ok && (mem_rd == ex_rs1_q),
                                    wb_fwd_ok && (wb_rd == ex_rs1_q));
    assign bus.fwd_b      = fwd_sel(mem_fwd_ok && (mem_rd == ex_rs2_q),
                                    wb_fwd_ok && (wb_rd == ex_rs2_q));
    assign bus.stall      = stall;
    assign bus.redirect   = redirect;
    assign bus.flush_ifid = redirect;
    assign bus.ex_alu_op  = ex_valid ? ex_ctrl[CR_ALU_LSB +: 3] : 3'b000;
    assign bus.mem_we     = mem_valid & mem_ctrl[CR_MEMWR];
    assign bus.mem_re     = mem_valid & mem_ctrl[CR_LOAD];
    assign bus.wb_we      = wb_valid & wb_ctrl[CR_REGWR];
    assign bus.wb_rd      = wb_rd;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;

    logic unused_ctrl;
    assign unused_ctrl = ^{ex_ctrl, mem_ctrl, wb_ctrl};
endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// Directed vector bench for pipe_ctrl_tracker, plus counter saturation on a narrow-counter instance.
module tb_pipe_ctrl_tracker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_tracker_if bus ();
    pipe_ctrl_tracker_if #(.CNT_W(3)) nbus ();

    pipe_ctrl_tracker dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    pipe_ctrl_tracker #(.CNT_W(3)) dut_n (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (nbus)
    );

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [9:0]  ctrl;
        logic [3:0]  rs1, rs2, rd;
        logic        bt;
        logic        exv;
        logic        stall, redir;
        logic [2:0]  alu;
        logic [1:0]  fa, fb;
        logic        mwe, mre, wwe;
        logic [3:0]  wrd;
        logic [15:0] scnt, fcnt;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    vec_t vecs[38];

    function automatic vec_t v(input logic r, input logic vl, input logic [9:0] c,
                               input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                               input logic b, input logic ev, input logic st, input logic rd,
                               input logic [2:0] al, input logic [1:0] a, input logic [1:0] bb,
                               input logic mw, input logic mr, input logic ww,
                               input logic [3:0] wr, input logic [15:0] sc,
                               input logic [15:0] fc);
        vec_t t;
        t.rst_n = r; t.vld = vl; t.ctrl = c; t.rs1 = s1; t.rs2 = s2; t.rd = d; t.bt = b;
        t.exv = ev; t.stall = st; t.redir = rd; t.alu = al; t.fa = a; t.fb = bb;
        t.mwe = mw; t.mre = mr; t.wwe = ww; t.wrd = wr; t.scnt = sc; t.fcnt = fc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vl, input logic [9:0] c, input logic [3:0] s1,
                         input logic [3:0] s2, input logic [3:0] d, input logic b);
        bus.id_valid = vl; bus.id_ctrl = c; bus.id_rs1 = s1; bus.id_rs2 = s2;
        bus.id_rd = d; bus.ex_branch_taken = b;
    endtask

    task automatic ndrive(input logic vl, input logic [9:0] c, input logic [3:0] s1,
                          input logic [3:0] d);
        nbus.id_valid = vl; nbus.id_ctrl = c; nbus.id_rs1 = s1; nbus.id_rs2 = 4'd0;
        nbus.id_rd = d; nbus.ex_branch_taken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //         rst vld ctrl   rs1 rs2 rd bt  exv stl rdr alu fa fb mwe mre wwe wrd sc fc
        vecs[0]  = v(0, 1, 'h341, 1, 2, 5, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = v(1, 1, 'h341, 1, 2, 5, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = v(1, 1, 'h050, 6, 7, 3, 0,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = v(1, 1, 'h341, 3, 4, 8, 0,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = v(1, 1, 'h341, 3, 4, 8, 0,   0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 1, 0);
        vecs[5]  = v(1, 0, 'h000, 0, 0, 0, 0,   1, 0, 0, 1, 2, 0, 0, 0, 1, 3, 1, 0);
        vecs[6]  = v(1, 1, 'h341, 9, 10, 2, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[7]  = v(1, 1, 'h243, 2, 11, 12, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 8, 1, 0);
        vecs[8]  = v(1, 1, 'h341, 2, 13, 14, 0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 0);
        vecs[9]  = v(1, 0, 'h000, 0, 0, 0, 0,   1, 0, 0, 1, 2, 0, 0, 0, 1, 2, 1, 0);
        vecs[10] = v(1, 1, 'h341, 9, 10, 7, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 1, 0);
        vecs[11] = v(1, 1, 'h341, 9, 10, 7, 0,  1, 0, 0, 1, 0, 0, 0, 0, 1, 14, 1, 0);
        vecs[12] = v(1, 1, 'h341, 7, 7, 15, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[13] = v(1, 0, 'h000, 0, 0, 0, 0,   1, 0, 0, 1, 1, 1, 0, 0, 1, 7, 1, 0);
        vecs[14] = v(1, 0, 'h000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0);
        vecs[15] = v(1, 1, 'h050, 9, 9, 3, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 15, 1, 0);
        vecs[16] = v(1, 1, 'h040, 3, 3, 4, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[17] = v(1, 0, 'h000, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        vecs[18] = v(1, 0, 'h000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0);
        vecs[19] = v(1, 1, 'h208, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0);
        vecs[20] = v(1, 1, 'h341, 1, 1, 5, 1,   1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[21] = v(1, 0, 'h000, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        vecs[22] = v(1, 1, 'h208, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        vecs[23] = v(1, 1, 'h341, 1, 1, 5, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        vecs[24] = v(1, 0, 'h000, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
        vecs[25] = v(1, 1, 'h0D0, 1, 1, 6, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        vecs[26] = v(1, 1, 'h341, 6, 1, 8, 0,   1, 0, 1, 0, 0, 0, 0, 0, 1, 5, 1, 1);
        vecs[27] = v(1, 0, 'h000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
        vecs[28] = v(1, 1, 'h220, 1, 2, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1, 2);
        vecs[29] = v(1, 0, 'h000, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        vecs[30] = v(1, 0, 'h000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2);
        vecs[31] = v(1, 0, 'h000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        vecs[32] = v(1, 1, 'h341, 1, 2, 9, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        vecs[33] = v(1, 1, 'h341, 1, 2, 10, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2);
        vecs[34] = v(1, 0, 'h000, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 2);
        vecs[35] = v(0, 1, 'h341, 1, 2, 11, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 2);
        vecs[36] = v(0, 1, 'h341, 1, 2, 11, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[37] = v(1, 0, 'h000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        ndrive(1'b0, 10'h000, 4'd0, 4'd0);
        drive(1'b1, 10'h341, 4'd1, 4'd2, 4'd5, 1'b0);
        rst_n = 1'b0;
        next_cycle();

        for (int i = 0; i < 38; i++) begin
            rst_n = vecs[i].rst_n;
            drive(vecs[i].vld, vecs[i].ctrl, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].bt);
            @(negedge clk);
            chk($sformatf("row%0d.stall", i), 32'(bus.stall), 32'(vecs[i].stall));
            chk($sformatf("row%0d.redirect", i), 32'(bus.redirect), 32'(vecs[i].redir));
            chk($sformatf("row%0d.flush_ifid", i), 32'(bus.flush_ifid), 32'(vecs[i].redir));
            chk($sformatf("row%0d.ex_alu_op", i), 32'(bus.ex_alu_op), 32'(vecs[i].alu));
            chk($sformatf("row%0d.mem_we", i), 32'(bus.mem_we), 32'(vecs[i].mwe));
            chk($sformatf("row%0d.mem_re", i), 32'(bus.mem_re), 32'(vecs[i].mre));
            chk($sformatf("row%0d.wb_we", i), 32'(bus.wb_we), 32'(vecs[i].wwe));
            chk($sformatf("row%0d.stall_cnt", i), 32'(bus.stall_cnt), 32'(vecs[i].scnt));
            chk($sformatf("row%0d.flush_cnt", i), 32'(bus.flush_cnt), 32'(vecs[i].fcnt));
            if (vecs[i].exv) begin
                chk($sformatf("row%0d.fwd_a", i), 32'(bus.fwd_a), 32'(vecs[i].fa));
                chk($sformatf("row%0d.fwd_b", i), 32'(bus.fwd_b), 32'(vecs[i].fb));
            end
            if (vecs[i].wwe || !vecs[i].rst_n) begin
                chk($sformatf("row%0d.wb_rd", i), 32'(bus.wb_rd), 32'(vecs[i].wrd));
            end
            next_cycle();
        end

        // Back-to-back load/dependent pairs: one stall per pair, 3-bit counter sticks at 7.
        for (int k = 1; k <= 10; k++) begin
            ndrive(1'b1, 10'h050, 4'd0, 4'd3);
            @(negedge clk);
            chk($sformatf("sat_stall%0d.cnt", k), 32'(nbus.stall_cnt), (k - 1 > 7) ? 7 : k - 1);
            next_cycle();
            ndrive(1'b1, 10'h341, 4'd3, 4'd9);
            @(negedge clk);
            chk($sformatf("sat_stall%0d.stall", k), 32'(nbus.stall), 32'd1);
            next_cycle();
        end
        ndrive(1'b0, 10'h000, 4'd0, 4'd0);
        @(negedge clk);
        chk("sat_stall.final", 32'(nbus.stall_cnt), 32'd7);
        next_cycle();

        for (int k = 1; k <= 10; k++) begin
            ndrive(1'b1, 10'h080, 4'd0, 4'd0);
            @(negedge clk);
            chk($sformatf("sat_flush%0d.cnt", k), 32'(nbus.flush_cnt), (k - 1 > 7) ? 7 : k - 1);
            next_cycle();
            ndrive(1'b0, 10'h000, 4'd0, 4'd0);
            @(negedge clk);
            chk($sformatf("sat_flush%0d.redirect", k), 32'(nbus.redirect), 32'd1);
            next_cycle();
        end
        @(negedge clk);
        chk("sat_flush.final", 32'(nbus.flush_cnt), 32'd7);
        chk("sat_flush.stall_hold", 32'(nbus.stall_cnt), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
